hazard_ctrl_sb: RTL and testbench
=================================

Name: hazard_ctrl_sb

Overview:
Parametrised scoreboard-based hazard controller for the pipelined core; successor to the combinational load-use/branch hazard unit. Tracks in-flight load destinations and pending flag writes with per-entry countdowns, so load and flag latency are parameters rather than fixed at one cycle. Drives the IF/ID stall and the IF/ID flush requests. Keeps a saturating stall-cycle counter for performance debug. Sits beside the ID stage and observes the ID instruction plus branch resolution from EX.

Parameters:
NUM_REGS, 16, number of architectural registers (power of 2)
ADDR_W, 4, register address width, log2(NUM_REGS)
LOAD_LAT, 1, cycles after issue before a load result is forwardable (1..7)
FLAG_LAT, 2, cycles after issue before flags from a flag-setter are valid for a branch (1..7)
ZERO_REG, 1, 1 = register 0 is hardwired zero and never tracked
STORE_FWD, 1, 1 = store-data operand may be forwarded from MEM, so it needs no stall on the final count
STALL_CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_rs  in  ADDR_W  ID source register 1
id_rt  in  ADDR_W  ID source register 2
id_rs_used  in  1  instruction reads rs
id_rt_used  in  1  instruction reads rt
id_is_store  in  1  rt is store data
id_is_load  in  1  ID instruction is a load
id_rd  in  ADDR_W  ID destination register
id_sets_flags  in  1  ID instruction writes flags
id_br_cond  in  1  ID is a conditional branch (needs flags); unconditional = 0
br_taken  in  1  branch resolved taken this cycle
mem_stall  in  1  memory-system freeze
cnt_clr  in  1  synchronous clear of stall_cnt
stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
if_flush  out  1  flush IF/ID register
id_flush  out  1  flush ID/EX register
stall_cause  out  2  00 none, 01 load-use, 10 flag-wait, 11 both
stall_cnt  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_n low, asynchronous): all scoreboard counters, flag_cnt and stall_cnt go to 0. While rst_n is low, stall, if_flush, id_flush and stall_cause are forced to 0.
- Scoreboard: one counter ld_cnt[r] per register, width ceil(log2(LOAD_LAT+1)). Register r is pending while ld_cnt[r] != 0.
- issue = id_valid & ~stall & ~br_taken & ~mem_stall.
- On issue with id_is_load, ld_cnt[id_rd] <= LOAD_LAT. Skip this when ZERO_REG=1 and id_rd == 0.
- On issue with id_sets_flags, flag_cnt <= FLAG_LAT.
- Each cycle with mem_stall=0, every nonzero counter decrements by 1. A set in the same cycle wins over the decrement. A reload while the counter is nonzero restarts it at the full latency.
- When mem_stall=1, all counters and stall_cnt hold.
- ld_haz = id_valid & ((id_rs_used & ld_cnt[id_rs]!=0) | (id_rt_used & ld_cnt[id_rt]!=0 & ~(STORE_FWD & id_is_store & ld_cnt[id_rt]==1))).
- Reads of register 0 never hazard when ZERO_REG=1.
- fl_haz = id_valid & id_br_cond & flag_cnt != 0.
- stall = (ld_haz | fl_haz) & ~br_taken. stall_cause = {fl_haz, ld_haz}, masked to 00 when br_taken=1.
- id_flush = stall | br_taken. if_flush = br_taken.
- br_taken has priority over a stall in the same cycle: the ID instruction is killed and nothing is recorded for it.
- Outputs are combinational from registered state plus current inputs; zero latency from ID inputs to stall.
- stall_cnt increments on each clock with stall=1 and mem_stall=0. It saturates at all-ones. cnt_clr takes priority over increment.
- A long stall chain (load followed by a dependent conditional branch) stalls until both hazards clear.

Test Plan:
- Load-use, LOAD_LAT=1: issue load r3, next cycle ID add reads r3 -> stall=1 for 1 cycle, stall_cause=01, id_flush=1; then stall=0.
- LOAD_LAT=3 (alternate build): load r5, dependent instruction follows immediately -> stall=1 for exactly 3 cycles; an independent instruction reading r6 -> no stall.
- Store data, STORE_FWD=1, LOAD_LAT=1: load r2, then store with id_rt=r2 as data -> no stall. The same store using r2 as base (rs) -> 1-cycle stall.
- Flag wait, FLAG_LAT=2: issue add (sets flags), then conditional branch -> stall=1 for 2 cycles, stall_cause=10. An unconditional branch (id_br_cond=0) in the same position -> no stall.
- Priority and freeze: br_taken=1 coinciding with a load-use hazard -> stall=0, if_flush=1, id_flush=1, no scoreboard update. mem_stall=1 for 4 cycles mid-countdown -> counters and stall_cnt hold, resume after.
- Reset and counter: drop rst_n mid-countdown with stall=1 -> stall=0 immediately, all counts 0. Force 70000 stall cycles with STALL_CNT_W=16 -> stall_cnt=16'hFFFF. cnt_clr -> 0.

Source files
------------

// File: rtl/hazard_ctrl_sb_if.sv
// hazard_ctrl_sb_if: ID-stage / EX-resolution bundle between the pipeline and
// the scoreboard hazard controller.
//   master : pipeline side. Drives the ID instruction fields, br_taken,
//            mem_stall and cnt_clr. Receives the stall and flush requests.
//   slave  : hazard controller side. Directions are the reverse of master.
interface hazard_ctrl_sb_if #(
    parameter int ADDR_W      = 4,
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid;
    logic [ADDR_W-1:0]      id_rs;
    logic [ADDR_W-1:0]      id_rt;
    logic                   id_rs_used;
    logic                   id_rt_used;
    logic                   id_is_store;
    logic                   id_is_load;
    logic [ADDR_W-1:0]      id_rd;
    logic                   id_sets_flags;
    logic                   id_br_cond;
    logic                   br_taken;
    logic                   mem_stall;
    logic                   cnt_clr;
    logic                   stall;
    logic                   if_flush;
    logic                   id_flush;
    logic [1:0]             stall_cause;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_is_store,
               id_is_load, id_rd, id_sets_flags, id_br_cond, br_taken,
               mem_stall, cnt_clr,
        input  stall, if_flush, id_flush, stall_cause, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_is_store,
               id_is_load, id_rd, id_sets_flags, id_br_cond, br_taken,
               mem_stall, cnt_clr,
        output stall, if_flush, id_flush, stall_cause, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: scoreboard-based load-use / flag-wait hazard controller.
// Each register has a countdown that is loaded with LOAD_LAT when a load to
// that register issues. A single flag countdown is loaded with FLAG_LAT when
// a flag-setter issues. The ID instruction stalls while any source it reads
// (or, for a conditional branch, the flags) is still counting down.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hazard_ctrl_sb_if slave. Carries the ID instruction fields,
//                br_taken, mem_stall and cnt_clr in, and stall, if_flush,
//                id_flush, stall_cause and stall_cnt out.
module hazard_ctrl_sb #(
    parameter int NUM_REGS    = 16,
    parameter int ADDR_W      = 4,
    parameter int LOAD_LAT    = 1,
    parameter int FLAG_LAT    = 2,
    parameter int ZERO_REG    = 1,
    parameter int STORE_FWD   = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_sb_if.slave bus
);
    localparam int LD_W = $clog2(LOAD_LAT + 1);
    localparam int FL_W = $clog2(FLAG_LAT + 1);

    logic [NUM_REGS-1:0][LD_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [FL_W-1:0]               flag_cnt_q, flag_cnt_d;
    logic [STALL_CNT_W-1:0]        stall_cnt_q, stall_cnt_d;

    logic rs_pend, rt_pend, rt_last, rt_fwd;
    logic ld_haz, fl_haz, stall_int, issue, rd_zero;

    // Register 0 is never written into the scoreboard. It is also masked on
    // reads, so a hardwired zero register can never hazard.
    assign rs_pend = (ld_cnt_q[bus.id_rs] != '0) && !((ZERO_REG != 0) && (bus.id_rs == '0));
    assign rt_pend = (ld_cnt_q[bus.id_rt] != '0) && !((ZERO_REG != 0) && (bus.id_rt == '0));
    assign rt_last = (ld_cnt_q[bus.id_rt] == LD_W'(1));
    // Store data is consumed in MEM, so on the final count it can be
    // forwarded from the load and does not need a stall.
    assign rt_fwd  = (STORE_FWD != 0) && bus.id_is_store && rt_last;

    assign ld_haz = bus.id_valid && ((bus.id_rs_used && rs_pend) ||
                                     (bus.id_rt_used && rt_pend && !rt_fwd));
    assign fl_haz = bus.id_valid && bus.id_br_cond && (flag_cnt_q != '0);

    // A taken branch kills the ID instruction, so it overrides any stall.
    assign stall_int = (ld_haz || fl_haz) && !bus.br_taken;
    assign issue     = bus.id_valid && !stall_int && !bus.br_taken && !bus.mem_stall;
    assign rd_zero   = (ZERO_REG != 0) && (bus.id_rd == '0);

    // Outputs are gated by rst_n so they read zero while reset is held,
    // independent of whatever the ID inputs are showing.
    assign bus.stall       = stall_int && rst_n;
    assign bus.if_flush    = bus.br_taken && rst_n;
    assign bus.id_flush    = (stall_int || bus.br_taken) && rst_n;
    assign bus.stall_cause = (bus.br_taken || !rst_n) ? 2'b00 : {fl_haz, ld_haz};
    assign bus.stall_cnt   = stall_cnt_q;

    always_comb begin
        ld_cnt_d    = ld_cnt_q;
        flag_cnt_d  = flag_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!bus.mem_stall) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (ld_cnt_q[r] != '0) ld_cnt_d[r] = ld_cnt_q[r] - LD_W'(1);
            end
            if (flag_cnt_q != '0) flag_cnt_d = flag_cnt_q - FL_W'(1);
            // A set issued this cycle overrides the decrement above, which
            // also restarts a counter that was still running.
            if (issue && bus.id_is_load && !rd_zero) ld_cnt_d[bus.id_rd] = LD_W'(LOAD_LAT);
            if (issue && bus.id_sets_flags) flag_cnt_d = FL_W'(FLAG_LAT);
            if (stall_int && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
        if (bus.cnt_clr) stall_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_q    <= '0;
            flag_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            ld_cnt_q    <= ld_cnt_d;
            flag_cnt_q  <= flag_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_sb.sv
module tb_hazard_ctrl_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_sb_if #(.ADDR_W(4), .STALL_CNT_W(16)) bi();
    hazard_ctrl_sb_if #(.ADDR_W(4), .STALL_CNT_W(16)) b3();
    hazard_ctrl_sb_if #(.ADDR_W(4), .STALL_CNT_W(16)) b7();

    hazard_ctrl_sb u_dut (.clk(clk), .rst_n(rst_n), .bus(bi));
    hazard_ctrl_sb #(.LOAD_LAT(3)) u_l3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    hazard_ctrl_sb #(.LOAD_LAT(7), .FLAG_LAT(7)) u_sat (.clk(clk), .rst_n(rst_n), .bus(b7));

    typedef struct {
        logic       v;
        logic [3:0] rs;
        logic       rsu;
        logic [3:0] rt;
        logic       rtu, st, ld;
        logic [3:0] rd;
        logic       sf, bc, bt, ms;
        logic       e_st, e_iff, e_idf;
        logic [1:0] e_c;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[32];

    function automatic vec_t mk(input logic v, input logic [3:0] rs, input logic rsu,
                                input logic [3:0] rt, input logic rtu, input logic st,
                                input logic ld, input logic [3:0] rd, input logic sf,
                                input logic bc, input logic bt, input logic ms,
                                input logic e_st, input logic e_iff, input logic e_idf,
                                input logic [1:0] e_c, input logic [15:0] e_cnt);
        vec_t x;
        x.v = v; x.rs = rs; x.rsu = rsu; x.rt = rt; x.rtu = rtu; x.st = st;
        x.ld = ld; x.rd = rd; x.sf = sf; x.bc = bc; x.bt = bt; x.ms = ms;
        x.e_st = e_st; x.e_iff = e_iff; x.e_idf = e_idf; x.e_c = e_c; x.e_cnt = e_cnt;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic d3(input logic v, input logic [3:0] rs, input logic rsu,
                      input logic [3:0] rt, input logic rtu, input logic st,
                      input logic ld, input logic [3:0] rd);
        b3.id_valid = v; b3.id_rs = rs; b3.id_rs_used = rsu; b3.id_rt = rt;
        b3.id_rt_used = rtu; b3.id_is_store = st; b3.id_is_load = ld; b3.id_rd = rd;
    endtask

    // One cycle of the LOAD_LAT=3 build: drive at negedge, check stall shortly after.
    task automatic step3(input string nm, input logic v, input logic [3:0] rs, input logic rsu,
                         input logic [3:0] rt, input logic rtu, input logic st,
                         input logic ld, input logic [3:0] rd, input logic e_st);
        @(negedge clk);
        d3(v, rs, rsu, rt, rtu, st, ld, rd);
        #1;
        chk(nm, b3.stall, e_st);
    endtask

    initial begin
        bi.id_valid = 0; bi.id_rs = 0; bi.id_rt = 0; bi.id_rs_used = 0; bi.id_rt_used = 0;
        bi.id_is_store = 0; bi.id_is_load = 0; bi.id_rd = 0; bi.id_sets_flags = 0;
        bi.id_br_cond = 0; bi.br_taken = 0; bi.mem_stall = 0; bi.cnt_clr = 0;
        b3.id_valid = 0; b3.id_rs = 0; b3.id_rt = 0; b3.id_rs_used = 0; b3.id_rt_used = 0;
        b3.id_is_store = 0; b3.id_is_load = 0; b3.id_rd = 0; b3.id_sets_flags = 0;
        b3.id_br_cond = 0; b3.br_taken = 0; b3.mem_stall = 0; b3.cnt_clr = 0;
        b7.id_valid = 0; b7.id_rs = 0; b7.id_rt = 0; b7.id_rs_used = 0; b7.id_rt_used = 0;
        b7.id_is_store = 0; b7.id_is_load = 0; b7.id_rd = 0; b7.id_sets_flags = 0;
        b7.id_br_cond = 0; b7.br_taken = 0; b7.mem_stall = 0; b7.cnt_clr = 0;

        //            v  rs rsu rt rtu st ld rd sf bc bt ms  stl iff idf c  cnt
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // idle
        vecs[1]  = mk(1, 1, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0); // load r3
        vecs[2]  = mk(1, 3, 1, 4, 1, 0, 0, 5, 0, 0, 0, 0,  1, 0, 1, 1, 0); // add r3 -> stall
        vecs[3]  = mk(1, 3, 1, 4, 1, 0, 0, 5, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        vecs[4]  = mk(1, 1, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0, 1); // load r2
        vecs[5]  = mk(1, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1); // store data r2: fwd
        vecs[6]  = mk(1, 1, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0, 1); // load r2
        vecs[7]  = mk(1, 2, 1, 4, 1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 1); // store base r2
        vecs[8]  = mk(1, 2, 1, 4, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2);
        vecs[9]  = mk(1, 1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  0, 0, 0, 0, 2); // flag setter
        vecs[10] = mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 2, 2); // cond branch
        vecs[11] = mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 2, 3);
        vecs[12] = mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 4);
        vecs[13] = mk(1, 1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  0, 0, 0, 0, 4); // flag setter
        vecs[14] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4); // uncond branch
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4);
        vecs[16] = mk(1, 1, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 4); // load r3
        vecs[17] = mk(1, 3, 1, 0, 0, 0, 1, 7, 0, 0, 1, 0,  0, 1, 1, 0, 4); // killed load r7
        vecs[18] = mk(1, 7, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0,  0, 0, 0, 0, 4); // r7 not pending
        vecs[19] = mk(1, 1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0,  0, 0, 0, 0, 4); // flag setter
        vecs[20] = mk(1, 1, 1, 0, 0, 0, 1, 8, 0, 0, 0, 0,  0, 0, 0, 0, 4); // load r8
        vecs[21] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 1, 3, 4); // both hazards
        vecs[22] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 5);
        vecs[23] = mk(1, 1, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 5); // load r3
        vecs[24] = mk(1, 3, 1, 0, 0, 0, 0, 5, 0, 0, 0, 1,  1, 0, 1, 1, 5); // frozen
        vecs[25] = mk(1, 3, 1, 0, 0, 0, 0, 5, 0, 0, 0, 1,  1, 0, 1, 1, 5);
        vecs[26] = mk(1, 3, 1, 0, 0, 0, 0, 5, 0, 0, 0, 1,  1, 0, 1, 1, 5);
        vecs[27] = mk(1, 3, 1, 0, 0, 0, 0, 5, 0, 0, 0, 1,  1, 0, 1, 1, 5);
        vecs[28] = mk(1, 3, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0,  1, 0, 1, 1, 5); // resumes
        vecs[29] = mk(1, 3, 1, 0, 0, 0, 0, 5, 0, 0, 0, 0,  0, 0, 0, 0, 6);
        vecs[30] = mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 6); // load r0
        vecs[31] = mk(1, 0, 1, 0, 1, 0, 0, 5, 0, 0, 0, 0,  0, 0, 0, 0, 6); // read r0

        // reset state
        #3;
        chk("rst stall", bi.stall, 0);
        chk("rst id_flush", bi.id_flush, 0);
        chk("rst stall_cnt", bi.stall_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bi.id_valid = vecs[i].v; bi.id_rs = vecs[i].rs; bi.id_rs_used = vecs[i].rsu;
            bi.id_rt = vecs[i].rt; bi.id_rt_used = vecs[i].rtu; bi.id_is_store = vecs[i].st;
            bi.id_is_load = vecs[i].ld; bi.id_rd = vecs[i].rd; bi.id_sets_flags = vecs[i].sf;
            bi.id_br_cond = vecs[i].bc; bi.br_taken = vecs[i].bt; bi.mem_stall = vecs[i].ms;
            #1;
            chk($sformatf("v%0d stall", i), bi.stall, vecs[i].e_st);
            chk($sformatf("v%0d if_flush", i), bi.if_flush, vecs[i].e_iff);
            chk($sformatf("v%0d id_flush", i), bi.id_flush, vecs[i].e_idf);
            chk($sformatf("v%0d cause", i), bi.stall_cause, vecs[i].e_c);
            chk($sformatf("v%0d stall_cnt", i), bi.stall_cnt, vecs[i].e_cnt);
        end

        // cnt_clr on the main build
        @(negedge clk);
        bi.id_valid = 0; bi.cnt_clr = 1;
        #1 chk("clr before edge", bi.stall_cnt, 6);
        @(negedge clk);
        bi.cnt_clr = 0;
        #1 chk("clr after edge", bi.stall_cnt, 0);

        // LOAD_LAT=3: three-cycle stall, restart on reload, store forwarding on last count
        step3("l3 load r5",      1, 6, 1, 0, 0, 0, 1, 5, 0);
        step3("l3 dep c1",       1, 5, 1, 0, 0, 0, 0, 7, 1);
        step3("l3 dep c2",       1, 5, 1, 0, 0, 0, 0, 7, 1);
        step3("l3 dep c3",       1, 5, 1, 0, 0, 0, 0, 7, 1);
        step3("l3 dep clear",    1, 5, 1, 0, 0, 0, 0, 7, 0);
        step3("l3 load r5 a",    1, 6, 1, 0, 0, 0, 1, 5, 0);
        step3("l3 reload indep", 1, 6, 1, 0, 0, 0, 1, 5, 0);
        step3("l3 rl dep c1",    1, 5, 1, 0, 0, 0, 0, 7, 1);
        step3("l3 rl dep c2",    1, 5, 1, 0, 0, 0, 0, 7, 1);
        step3("l3 rl dep c3",    1, 5, 1, 0, 0, 0, 0, 7, 1);
        step3("l3 rl clear",     1, 5, 1, 0, 0, 0, 0, 7, 0);
        step3("l3 load r5 b",    1, 6, 1, 0, 0, 0, 1, 5, 0);
        step3("l3 store c3",     1, 6, 1, 5, 1, 1, 0, 0, 1);
        step3("l3 store c2",     1, 6, 1, 5, 1, 1, 0, 0, 1);
        step3("l3 store fwd",    1, 6, 1, 5, 1, 1, 0, 0, 0);
        step3("l3 idle",         0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("l3 stall_cnt", b3.stall_cnt, 8);

        // asynchronous reset in the middle of a countdown
        step3("l3 load r5 c",    1, 6, 1, 0, 0, 0, 1, 5, 0);
        step3("l3 pre-rst c1",   1, 5, 1, 0, 0, 0, 0, 7, 1);
        step3("l3 pre-rst c2",   1, 5, 1, 0, 0, 0, 0, 7, 1);
        rst_n = 1'b0;
        #1;
        chk("rst mid stall", b3.stall, 0);
        chk("rst mid id_flush", b3.id_flush, 0);
        chk("rst mid cause", b3.stall_cause, 0);
        chk("rst mid stall_cnt", b3.stall_cnt, 0);
        #1 rst_n = 1'b1;
        #1 chk("rst release stall", b3.stall, 0);
        @(negedge clk);
        d3(0, 0, 0, 0, 0, 0, 0, 0);

        // saturation: a self-dependent load stalls 7 of every 8 cycles
        @(negedge clk);
        b7.id_valid = 1; b7.id_is_load = 1; b7.id_rd = 1; b7.id_rs = 1; b7.id_rs_used = 1;
        repeat (76000) @(posedge clk);
        @(negedge clk);
        chk("sat stall_cnt", b7.stall_cnt, 16'hFFFF);
        b7.cnt_clr = 1;
        @(negedge clk);
        b7.cnt_clr = 0;
        #1 chk("sat clr", b7.stall_cnt, 0);
        b7.id_valid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
